truth_table_scanner: RTL
========================

Name: truth_table_scanner

Overview:
- Sequential stimulus/response engine that sits on the driving side of a 4-input, 1-output combinational gate circuit.
- On start, drives every input combination 0..2^N_IN-1 onto the circuit, samples its output after a programmable settle time, and assembles the full truth table and minterm count.
- Provides in-hardware exhaustive characterization of the combinational exercise circuits, replacing hand-written vector lists.

Parameters:
- N_IN, 4, number of circuit inputs driven; vec_out MSB maps to input A.
- SETTLE, 1, extra hold cycles per vector before sampling; 0 allowed.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request a scan; sampled only in IDLE
- f_in  input  1  output of the circuit under evaluation
- vec_out  output  N_IN  input vector driven to the circuit ({A,B,C,D} for N_IN=4)
- busy  output  1  high while a scan is in progress
- done  output  1  one-cycle pulse when a scan completes
- table_out  output  2**N_IN  bit i = sampled f_in for vec_out==i
- minterm_count  output  N_IN+1  number of 1s in table_out

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: vec_out=0, busy=0, done=0, table_out=0, minterm_count=0; state IDLE; settle counter=0.
- States: IDLE, HOLD, DONE.
- IDLE:
  - start=1 at an edge moves to HOLD.
  - The same edge sets busy=1 and vec_out=0, clears table_out and minterm_count, and loads settle counter=SETTLE.
- HOLD:
  - Each vector is held for exactly SETTLE+1 cycles.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, the edge writes table_out[vec_out]=f_in, adds f_in to minterm_count, and reloads the counter.
  - On the same edge, if vec_out != 2^N_IN-1, increment vec_out; otherwise move to DONE, set vec_out=0, busy=0, done=1.
- DONE:
  - Lasts one cycle: done=1, then return to IDLE with done=0.
  - start is not accepted in DONE.
- Latency: done is high in the cycle starting 2^N_IN*(SETTLE+1) cycles after busy rises.
- table_out and minterm_count:
  - Hold final values from done until the next accepted start.
  - Mid-scan they show partial results; unsampled bits read 0.
- start while busy or in DONE: ignored; no restart, no effect on results.
- start held high continuously: a new scan starts on the first IDLE cycle after DONE.
- vec_out wrap: never wraps mid-scan; the final index ends the scan.
- minterm_count width N_IN+1: holds 2^N_IN without overflow.
- Reset mid-scan: next cycle all outputs return to reset values and state is IDLE; no done pulse.
- f_in is sampled raw; the settle window provides the combinational setup margin.

Optional Feature:
- Macro: TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN.
- When defined, adds the following ports:
  - expected  input  2**N_IN: golden truth table, sampled at start acceptance into an internal register.
  - mismatch  output  1: sticky; set when a sample differs from the golden bit.
  - mismatch_idx  output  N_IN: index of the first differing vector.
- mismatch and mismatch_idx clear on reset and on start acceptance.
- Later mismatches do not overwrite mismatch_idx.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset 2 cycles mid-random activity -> vec_out=0, busy=0, done=0, table_out=16'h0000, minterm_count=0.
- Functional scan:
  - Setup: SETTLE=1; f_in = (C|~D)&(A^B) computed combinationally from vec_out.
  - Required: busy for 32 cycles, done 32 cycles after busy rises, table_out=16'h0DD0, minterm_count=6, vec_out back to 0.
- Zero settle and full count: SETTLE=0, f_in tied 1 -> done 16 cycles after busy, table_out=16'hFFFF, minterm_count=16 (5'b10000).
- start handling:
  - Pulse start at vector 3 of a running scan -> no restart; results identical to an unperturbed scan.
  - Hold start high throughout -> second scan begins in the cycle after DONE; table_out reads 0 in the first busy cycle.
- Reset mid-scan: assert reset while vec_out=7 -> next cycle IDLE, all outputs 0, no done; a subsequent start yields a correct full 16'h0DD0 scan.
- Expect check (TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN defined):
  - Stimulus: expected=16'h0DD0, f_in=A^B.
  - Required: table_out=16'h0FF0, mismatch=1, mismatch_idx=5 (not 9).
  - Rerun with f_in matching expected -> mismatch=0.

Source files
------------

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives every input combination onto a small
// combinational circuit, samples its single output after a programmable
// settle time and assembles the full truth table plus a minterm count.
//
// Optional golden-table comparison is compiled in when the macro
// TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN is defined. It adds the ports
// expected / mismatch / mismatch_idx. Without the macro those ports and
// their logic are absent and everything else behaves identically.
//
// Handshake: start is a level request that is only looked at in IDLE.
// A request seen at a rising edge in IDLE is accepted on that edge.
// busy is high from that edge until the final sample, and done pulses
// for exactly one cycle afterwards. start seen while busy or in DONE is
// dropped: it does not restart the scan and does not touch the results.
// The FSM state is held in the state_q register (type state_t), which a
// checker can probe hierarchically.

module truth_table_scanner #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 f_in,
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch,
  output logic [N_IN-1:0]      mismatch_idx,
`endif
  output logic [N_IN-1:0]      vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   table_out,
  output logic [N_IN:0]        minterm_count
);

  localparam int NV = 2**N_IN;
  // Counter is at least one bit wide so SETTLE=0 still elaborates cleanly.
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0]   SETTLE_V = CW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NV-1:0]     table_q, table_d;
  logic [N_IN:0]     count_q, count_d;
  logic [CW-1:0]     cnt_q, cnt_d;

`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
  logic [NV-1:0]     exp_q, exp_d;
  logic              mism_q, mism_d;
  logic [N_IN-1:0]   midx_q, midx_d;
`endif

  // State and datapath registers; every output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      count_q <= '0;
      cnt_q   <= '0;
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
      exp_q   <= '0;
      mism_q  <= 1'b0;
      midx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
      exp_q   <= exp_d;
      mism_q  <= mism_d;
      midx_q  <= midx_d;
`endif
    end
  end

  // Next-state and next-output logic for the IDLE -> HOLD -> DONE scan.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    count_d = count_q;
    cnt_d   = cnt_q;
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
    exp_d   = exp_q;
    mism_d  = mism_q;
    midx_d  = midx_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          // Accepting a request wipes the previous results so that a
          // reader never sees stale bits for vectors not yet sampled.
          state_d = HOLD;
          busy_d  = 1'b1;
          vec_d   = '0;
          table_d = '0;
          count_d = '0;
          cnt_d   = SETTLE_V;
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
          exp_d   = expected;
          mism_d  = 1'b0;
          midx_d  = '0;
`endif
        end
      end

      HOLD: begin
        if (cnt_q != '0) begin
          // Still inside the settle window for the current vector.
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Last cycle of this vector: capture the circuit output.
          table_d[vec_q] = f_in;
          count_d        = count_q + {{N_IN{1'b0}}, f_in};
          cnt_d          = SETTLE_V;
`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
          // Only the first disagreement is recorded; it stays sticky.
          if (!mism_q && (f_in != exp_q[vec_q])) begin
            mism_d = 1'b1;
            midx_d = vec_q;
          end
`endif
          if (vec_q != LAST_VEC) begin
            vec_d = vec_q + N_IN'(1);
          end else begin
            // Final index ends the scan; vec_out never wraps mid-scan.
            state_d = DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        // One-cycle completion pulse; start is deliberately not examined.
        state_d = IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vec_d   = '0;
      end
    endcase
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign table_out     = table_q;
  assign minterm_count = count_q;

`ifdef TRUTH_TABLE_SCANNER_EXPECT_CHECK_EN
  assign mismatch      = mism_q;
  assign mismatch_idx  = midx_q;
`endif

endmodule
